fp_exp_align: RTL

FP_EXP_ALIGN -- requirements
Module: fp_exp_align

---
 rtl/fp_align_pkg.sv | 12 +
 rtl/align_shift.sv | 25 ++
 rtl/fp_exp_align.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp_align_pkg.sv
// Shared constants for the floating-point exponent alignment pipeline.
package fp_align_pkg;

    localparam int GRS_W = 3;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_e;

endpackage

// File: rtl/align_shift.sv
// Logical right shift of a {mantissa, guard, round, sticky} word, folding every
// bit shifted out into the sticky position.
module align_shift #(
    parameter int W  = 27,
    parameter int SW = 8
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] shamt,
    output logic [W-1:0]  dout
);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic         lost;

    // Shift amounts >= W saturate naturally: shifted becomes zero and the mask
    // covers every bit, so sticky reduces to the OR of the whole input.
    always_comb begin
        shifted   = din >> shamt;
        lost_mask = ~({W{1'b1}} << shamt);
        lost      = |(din & lost_mask);
        dout      = {shifted[W-1:1], shifted[0] | lost};
    end

endmodule

// File: rtl/fp_exp_align.sv
// Two-stage exponent compare / mantissa align pipeline with valid-ready
// handshaking on both sides.
module fp_exp_align
    import fp_align_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W-1:0]       exp_a,
    input  logic [EXP_W-1:0]       exp_b,
    input  logic [MAN_W-1:0]       man_a,
    input  logic [MAN_W-1:0]       man_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       out_exp,
    output logic [1:0]             out_select,
    output logic [EXP_W-1:0]       out_shamt,
    output logic [MAN_W+GRS_W-1:0] out_man_a,
    output logic [MAN_W+GRS_W-1:0] out_man_b
);

    localparam int AW = MAN_W + GRS_W;

    logic             vld1_q, vld1_d, vld2_q, vld2_d;
    sel_e             sel1_q, sel1_d, sel2_q, sel2_d;
    logic [EXP_W-1:0] exp1_q, exp1_d, exp2_q, exp2_d;
    logic [EXP_W-1:0] shamt1_q, shamt1_d, shamt2_q, shamt2_d;
    logic [MAN_W-1:0] man_a1_q, man_a1_d, man_b1_q, man_b1_d;
    logic [AW-1:0]    man_a2_q, man_a2_d, man_b2_q, man_b2_d;

    logic             adv1, adv2;
    logic [EXP_W:0]   diff, neg_diff;
    logic [AW-1:0]    sh_in, sh_out;

    // A single shifter serves whichever operand has the smaller exponent;
    // for SEL_NONE the shift amount is zero, so B passes through unchanged.
    assign sh_in = (sel1_q == SEL_A) ? {man_a1_q, {GRS_W{1'b0}}}
                                     : {man_b1_q, {GRS_W{1'b0}}};

    align_shift #(.W(AW), .SW(EXP_W)) u_shift (
        .din   (sh_in),
        .shamt (shamt1_q),
        .dout  (sh_out)
    );

    always_comb begin
        adv2     = !vld2_q || out_ready;
        adv1     = !vld1_q || adv2;
        diff     = {1'b0, exp_a} - {1'b0, exp_b};
        neg_diff = '0 - diff;

        vld1_d   = vld1_q;
        sel1_d   = sel1_q;
        exp1_d   = exp1_q;
        shamt1_d = shamt1_q;
        man_a1_d = man_a1_q;
        man_b1_d = man_b1_q;
        vld2_d   = vld2_q;
        sel2_d   = sel2_q;
        exp2_d   = exp2_q;
        shamt2_d = shamt2_q;
        man_a2_d = man_a2_q;
        man_b2_d = man_b2_q;

        if (adv1) begin
            vld1_d = in_valid;
            if (in_valid) begin
                man_a1_d = man_a;
                man_b1_d = man_b;
                if (diff[EXP_W]) begin
                    sel1_d   = SEL_A;
                    shamt1_d = neg_diff[EXP_W-1:0];
                    exp1_d   = exp_b;
                end else if (diff == '0) begin
                    sel1_d   = SEL_NONE;
                    shamt1_d = '0;
                    exp1_d   = exp_b;
                end else begin
                    sel1_d   = SEL_B;
                    shamt1_d = diff[EXP_W-1:0];
                    exp1_d   = exp_a;
                end
            end
        end

        if (adv2) begin
            vld2_d = vld1_q;
            if (vld1_q) begin
                sel2_d   = sel1_q;
                exp2_d   = exp1_q;
                shamt2_d = shamt1_q;
                man_a2_d = (sel1_q == SEL_A) ? sh_out : {man_a1_q, {GRS_W{1'b0}}};
                man_b2_d = (sel1_q == SEL_B) ? sh_out : {man_b1_q, {GRS_W{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q   <= 1'b0;
            sel1_q   <= SEL_NONE;
            exp1_q   <= '0;
            shamt1_q <= '0;
            man_a1_q <= '0;
            man_b1_q <= '0;
            vld2_q   <= 1'b0;
            sel2_q   <= SEL_NONE;
            exp2_q   <= '0;
            shamt2_q <= '0;
            man_a2_q <= '0;
            man_b2_q <= '0;
        end else begin
            vld1_q   <= vld1_d;
            sel1_q   <= sel1_d;
            exp1_q   <= exp1_d;
            shamt1_q <= shamt1_d;
            man_a1_q <= man_a1_d;
            man_b1_q <= man_b1_d;
            vld2_q   <= vld2_d;
            sel2_q   <= sel2_d;
            exp2_q   <= exp2_d;
            shamt2_q <= shamt2_d;
            man_a2_q <= man_a2_d;
            man_b2_q <= man_b2_d;
        end
    end

    assign in_ready   = adv1;
    assign out_valid  = vld2_q;
    assign out_exp    = exp2_q;
    assign out_select = sel2_q;
    assign out_shamt  = shamt2_q;
    assign out_man_a  = man_a2_q;
    assign out_man_b  = man_b2_q;

endmodule
